// File: rtl/spi_txn_sched.sv
// spi_txn_sched: round-robin scheduler sharing one SPI byte-stream interface
// among NREQ requesters. Each granted command writes wr_len bytes, then holds
// spi_enable until rd_len read bytes have been routed back to the owner.
// Optional watchdog: define SPI_TXN_TIMEOUT_EN to abort stalled transactions
// (done_err=1). Without it done_err is tied low and TIMEOUT_CYC is unused.
//
// Handshake rule for every valid/ready pair on this block: a byte or command
// moves on a cycle where valid and ready are both high; no valid output here
// depends on its own ready input, and data is held stable while valid is high.
module spi_txn_sched #(
  parameter int NREQ        = 2,
  parameter int LEN_W       = 8,
  parameter int RX_SKIP     = 1,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*LEN_W-1:0] req_wr_len,
  input  logic [NREQ*LEN_W-1:0] req_rd_len,
  input  logic [NREQ*8-1:0]     tx_tdata,
  input  logic [NREQ-1:0]       tx_tvalid,
  output logic [NREQ-1:0]       tx_tready,
  output logic [7:0]            rx_tdata,
  output logic [NREQ-1:0]       rx_tvalid,
  input  logic [NREQ-1:0]       rx_tready,
  output logic [7:0]            spi_s_tdata,
  output logic                  spi_s_tvalid,
  input  logic                  spi_s_tready,
  input  logic [7:0]            spi_m_tdata,
  input  logic                  spi_m_tvalid,
  output logic                  spi_m_tready,
  output logic                  spi_enable,
  input  logic                  spi_csn,
  output logic                  busy,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  done_err,
  output logic [IW-1:0]         done_id,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int CW = LEN_W + 2;

  logic [1:0]       state, state_nx;
  logic [IW-1:0]    g, last;
  logic [LEN_W-1:0] wr_len_q, rd_len_q;
  logic [CW-1:0]    tx_cnt, rx_cnt, fwd_cnt;
  logic             en_q, csn_seen, err_q, to_hit;
  logic             arb_found;
  logic [IW-1:0]    arb_idx;
  logic [IW:0]      arb_sum;
  logic             st_idle, st_write, st_read, st_drain, active;
  logic             tx_more, rx_skip_ph, fwd_ph, hs_s, hs_m, grant, done_i;

  logic [LEN_W-1:0] wr_arr [NREQ];
  logic [LEN_W-1:0] rd_arr [NREQ];
  logic [7:0]       tx_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wr_arr[i] = req_wr_len[i*LEN_W +: LEN_W];
    assign rd_arr[i] = req_rd_len[i*LEN_W +: LEN_W];
    assign tx_arr[i] = tx_tdata[i*8 +: 8];
  end

  assign st_idle  = (state == S_IDLE);
  assign st_write = (state == S_WRITE);
  assign st_read  = (state == S_READ);
  assign st_drain = (state == S_DRAIN);
  assign active   = !st_idle;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, last} + (IW+1)'(1) + (IW+1)'(k);
      if (arb_sum >= (IW+1)'(NREQ)) arb_sum = arb_sum - (IW+1)'(NREQ);
      if (!arb_found && req_valid[arb_sum[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IW-1:0];
      end
    end
  end

  assign grant      = st_idle && arb_found;
  assign tx_more    = tx_cnt < CW'(wr_len_q);
  // Leading pipeline-fill bytes plus the echo of every written byte are junk
  assign rx_skip_ph = rx_cnt < (CW'(RX_SKIP) + CW'(wr_len_q));
  assign fwd_ph     = (st_write || st_read) && !rx_skip_ph && (fwd_cnt < CW'(rd_len_q));
  assign done_i     = st_drain && spi_csn && csn_seen;

  // Combinational routing of commands and byte streams for the current owner
  always_comb begin
    req_ready    = '0;
    tx_tready    = '0;
    spi_s_tvalid = 1'b0;
    spi_s_tdata  = 8'h00;
    rx_tvalid    = '0;
    rx_tdata     = 8'h00;
    spi_m_tready = 1'b0;
    gnt          = '0;
    if (grant) req_ready[arb_idx] = 1'b1;
    if (active) gnt[g] = 1'b1;
    if (st_write) begin
      spi_s_tvalid = tx_tvalid[g] && tx_more;
      spi_s_tdata  = tx_arr[g];
      tx_tready[g] = spi_s_tready && tx_more;
    end
    if (active) begin
      if (fwd_ph) begin
        rx_tvalid[g] = spi_m_tvalid;
        rx_tdata     = spi_m_tdata;
        spi_m_tready = rx_tready[g];
      end else begin
        spi_m_tready = 1'b1;
      end
    end
  end

  assign hs_s       = spi_s_tvalid && spi_s_tready;
  assign hs_m       = spi_m_tvalid && spi_m_tready;
  assign busy       = active;
  assign spi_enable = en_q;
  assign done       = done_i;
  assign done_id    = done_i ? g : '0;
  assign done_err   = done_i && err_q;
  assign dbg_state  = state;

  // Next-state selection for the transaction sequence
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (arb_found) state_nx = S_WRITE;
      S_WRITE: begin
        if (to_hit) state_nx = S_DRAIN;
        else if (tx_cnt == CW'(wr_len_q)) state_nx = (rd_len_q != '0) ? S_READ : S_DRAIN;
      end
      S_READ:  if (to_hit || fwd_cnt == CW'(rd_len_q)) state_nx = S_DRAIN;
      default: if (done_i) state_nx = S_IDLE;
    endcase
  end

  // State, owner, latched lengths, byte counters and registered enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      g        <= '0;
      last     <= IW'(NREQ - 1);
      wr_len_q <= '0;
      rd_len_q <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      fwd_cnt  <= '0;
      en_q     <= 1'b0;
      csn_seen <= 1'b0;
    end else begin
      state    <= state_nx;
      en_q     <= st_read && (fwd_cnt != CW'(rd_len_q)) && !to_hit;
      csn_seen <= st_drain && spi_csn;
      if (grant) begin
        g        <= arb_idx;
        last     <= arb_idx;
        wr_len_q <= wr_arr[arb_idx];
        rd_len_q <= rd_arr[arb_idx];
        tx_cnt   <= '0;
        rx_cnt   <= '0;
        fwd_cnt  <= '0;
      end else begin
        if (hs_s) tx_cnt <= tx_cnt + CW'(1);
        if (hs_m && rx_cnt != '1) rx_cnt <= rx_cnt + CW'(1);
        if (hs_m && fwd_ph) fwd_cnt <= fwd_cnt + CW'(1);
      end
    end
  end

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd;

  assign to_hit = (st_write || st_read) && !hs_s && !hs_m && (wd == WDW'(TIMEOUT_CYC - 1));

  // Watchdog: cycles without any SPI byte movement while writing or reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (!(st_write || st_read) || hs_s || hs_m) wd <= '0;
      else wd <= wd + WDW'(1);
      if (grant) err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign to_hit = 1'b0;
  assign err_q  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_sched.sv
// Directed bench for spi_txn_sched: byte-stream SPI model, requester drivers,
// expected-queue scoreboards for written and returned bytes, final report.
module tb_spi_txn_sched;
  localparam int NREQ = 2;
  localparam int LEN_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*LEN_W-1:0] req_wr_len = '0;
  logic [NREQ*LEN_W-1:0] req_rd_len = '0;
  logic [NREQ*8-1:0]     tx_tdata = '0;
  logic [NREQ-1:0]       tx_tvalid = '0;
  logic [NREQ-1:0]       tx_tready;
  logic [7:0]            rx_tdata;
  logic [NREQ-1:0]       rx_tvalid;
  logic [NREQ-1:0]       rx_tready = '1;
  logic [7:0]            spi_s_tdata;
  logic                  spi_s_tvalid;
  logic                  spi_s_tready = 1'b1;
  logic [7:0]            spi_m_tdata = 8'h00;
  logic                  spi_m_tvalid = 1'b0;
  logic                  spi_m_tready;
  logic                  spi_enable;
  logic                  spi_csn = 1'b1;
  logic                  busy;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  done_err;
  logic [0:0]            done_id;
  logic [1:0]            dbg_state;

  spi_txn_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .RX_SKIP(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr_len(req_wr_len), .req_rd_len(req_rd_len),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .spi_s_tdata(spi_s_tdata), .spi_s_tvalid(spi_s_tvalid), .spi_s_tready(spi_s_tready),
    .spi_m_tdata(spi_m_tdata), .spi_m_tvalid(spi_m_tvalid), .spi_m_tready(spi_m_tready),
    .spi_enable(spi_enable), .spi_csn(spi_csn),
    .busy(busy), .gnt(gnt), .done(done), .done_err(done_err), .done_id(done_id),
    .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard state
  logic [7:0] tx_q[$];      // bytes the active requester offers
  logic [7:0] m_q[$];       // bytes the SPI model will return
  logic [7:0] exp_tx_q[$];  // expected bytes on spi_s
  logic [7:0] exp_q[$];     // expected bytes on rx
  int gnt_log[$];
  int tx_id = 0;
  int exp_id = 0;
  int rx_got = 0;
  int done_cnt = 0;
  int last_done_id = 0;
  int last_done_err = 0;
  bit en_seen = 1'b0;
  bit tx_hs = 1'b0;
  bit m_hs = 1'b0;
  logic [7:0] mon_e;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  // SPI model and requester driver: advance queues just after each edge
  always begin
    @(posedge clk);
    #1;
    if (tx_hs && tx_q.size() != 0) void'(tx_q.pop_front());
    if (m_hs && m_q.size() != 0) void'(m_q.pop_front());
    tx_tvalid = '0;
    tx_tdata = '0;
    if (tx_q.size() != 0) begin
      tx_tvalid[tx_id] = 1'b1;
      tx_tdata[tx_id*8 +: 8] = tx_q[0];
    end
    spi_m_tvalid = (m_q.size() != 0);
    spi_m_tdata = (m_q.size() != 0) ? m_q[0] : 8'h00;
    spi_csn = !(spi_enable || tx_q.size() != 0 || m_q.size() != 0);
    spi_s_tready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: sample mid-cycle, score handshakes and invariants
  always @(negedge clk) begin
    tx_hs = |(tx_tvalid & tx_tready);
    m_hs = spi_m_tvalid && spi_m_tready;
    if (!rst) begin
      if (spi_s_tvalid && spi_s_tready) begin
        chk("spi_s_queued", exp_tx_q.size() != 0);
        if (exp_tx_q.size() != 0) begin
          mon_e = exp_tx_q.pop_front();
          chk("spi_s_data", spi_s_tdata === mon_e);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rx_tvalid[i] && rx_tready[i]) begin
          chk("rx_queued", exp_q.size() != 0);
          chk("rx_id", i == exp_id);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("rx_data", rx_tdata === mon_e);
          end
          rx_got++;
        end
        if (req_valid[i] && req_ready[i]) gnt_log.push_back(i);
      end
      chk("gnt_onehot", busy ? $onehot(gnt) : (gnt === '0));
      chk("tx_tready_owner", (tx_tready & ~gnt) === '0);
      if (spi_enable) en_seen = 1'b1;
      if (done) begin
        done_cnt++;
        last_done_id = int'(done_id);
        last_done_err = int'(done_err);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("done_count", done_cnt == target);
  endtask

  task automatic wait_enable(input int budget);
    int n;
    n = 0;
    while (!spi_enable && n < budget) begin
      step();
      n++;
    end
    chk("enable_rise", spi_enable === 1'b1);
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n;
    n = 0;
    while (rx_got < target && n < budget) begin
      step();
      n++;
    end
    chk("rx_count", rx_got == target);
  endtask

  task automatic issue(input int id, input int wr, input int rd);
    req_wr_len[id*LEN_W +: LEN_W] = LEN_W'(wr);
    req_rd_len[id*LEN_W +: LEN_W] = LEN_W'(rd);
    req_valid[id] = 1'b1;
    @(negedge clk);
    chk("req_ready", req_ready === NREQ'(1 << id));
    chk("busy_before", busy === 1'b0);
    step();
    req_valid[id] = 1'b0;
    chk("busy_after", busy === 1'b1);
    chk("gnt", gnt === NREQ'(1 << id));
  endtask

  // global bound
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int dprev;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", req_ready === '0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_gnt", gnt === '0);
    chk("rst_outs", {spi_s_tvalid, spi_m_tready, spi_enable, done, done_err, done_id} === '0);
    chk("rst_tx_rx", {tx_tready, rx_tvalid, rx_tdata, spi_s_tdata} === '0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy === 1'b0);

    // 1: req0 writes A5,3C, no read; three echo bytes all discarded
    tx_id = 0;
    tx_q = '{8'hA5, 8'h3C};
    exp_tx_q = '{8'hA5, 8'h3C};
    en_seen = 1'b0;
    base = rx_got;
    issue(0, 2, 0);
    m_q = '{8'h5A, 8'h66, 8'h77};
    wait_done(1, 200);
    chk("t1_done_id", last_done_id == 0);
    chk("t1_done_err", last_done_err == 0);
    chk("t1_no_enable", en_seen == 1'b0);
    chk("t1_tx_left", exp_tx_q.size() == 0);
    chk("t1_rx_drained", m_q.size() == 0);
    chk("t1_rx_none", rx_got == base);

    // 2: req1 writes 9F, reads 3; fill bytes skipped, enable drops after 3rd
    tx_id = 1;
    exp_id = 1;
    tx_q = '{8'h9F};
    exp_tx_q = '{8'h9F};
    issue(1, 1, 3);
    m_q = '{8'h01, 8'h02};
    wait_enable(100);
    base = rx_got;
    m_q.push_back(8'h11); m_q.push_back(8'h22); m_q.push_back(8'h33);
    exp_q = '{8'h11, 8'h22, 8'h33};
    wait_rx(base + 3, 100);
    chk("t2_enable_hold", spi_enable === 1'b1);
    step();
    chk("t2_enable_fall", spi_enable === 1'b0);
    wait_done(2, 200);
    chk("t2_done_id", last_done_id == 1);
    chk("t2_tx_left", exp_tx_q.size() == 0);
    chk("t2_rx_left", exp_q.size() == 0);

    // 3: both requesters persistent with empty commands -> grants 0,1,0
    gnt_log.delete();
    en_seen = 1'b0;
    req_wr_len = '0;
    req_rd_len = '0;
    req_valid = 2'b11;
    base = 0;
    while (gnt_log.size() < 3 && base < 200) begin
      step();
      base++;
    end
    req_valid = '0;
    wait_done(5, 200);
    chk("t3_grants", gnt_log.size() == 3);
    if (gnt_log.size() >= 3) begin
      chk("t3_grant0", gnt_log[0] == 0);
      chk("t3_grant1", gnt_log[1] == 1);
      chk("t3_grant2", gnt_log[2] == 0);
    end
    chk("t3_no_enable", en_seen == 1'b0);
    chk("t3_last_id", last_done_id == 0);

    // 4: req0 reads 4 with rx_tready low for 10 cycles
    exp_id = 0;
    issue(0, 0, 4);
    m_q = '{8'h01};
    wait_enable(100);
    step();
    step();
    rx_tready[0] = 1'b0;
    base = rx_got;
    m_q.push_back(8'hC1); m_q.push_back(8'hC2); m_q.push_back(8'hC3); m_q.push_back(8'hC4);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_stall_tready", spi_m_tready === 1'b0);
      chk("t4_stall_valid", rx_tvalid[0] === 1'b1);
    end
    step();
    rx_tready[0] = 1'b1;
    wait_rx(base + 4, 100);
    wait_done(6, 200);
    chk("t4_rx_left", exp_q.size() == 0);
    chk("t4_m_left", m_q.size() == 0);

    // 5: reset in READ after 1 of 4 bytes, then a normal transaction
    exp_id = 1;
    issue(1, 0, 4);
    m_q = '{8'h01};
    wait_enable(100);
    base = rx_got;
    m_q.push_back(8'hD1);
    exp_q = '{8'hD1};
    wait_rx(base + 1, 100);
    dprev = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy === 1'b0);
    chk("t5_rst_gnt", gnt === '0);
    chk("t5_rst_outs", {spi_enable, spi_m_tready, rx_tvalid, done} === '0);
    m_q.delete(); exp_q.delete(); tx_q.delete(); exp_tx_q.delete();
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5_no_done", done_cnt == dprev);
    exp_id = 0;
    tx_id = 0;
    tx_q = '{8'hE7};
    exp_tx_q = '{8'hE7};
    issue(0, 1, 1);
    m_q = '{8'h01, 8'h02};
    wait_enable(100);
    base = rx_got;
    m_q.push_back(8'hF0);
    exp_q = '{8'hF0};
    wait_rx(base + 1, 100);
    wait_done(dprev + 1, 200);
    chk("t5_done_id", last_done_id == 0);
    chk("t5_tx_left", exp_tx_q.size() == 0);
    chk("t5_rx_left", exp_q.size() == 0);

`ifdef SPI_TXN_TIMEOUT_EN
    // 6: SPI silent during READ -> watchdog aborts with error
    dprev = done_cnt;
    issue(0, 0, 1);
    wait_done(dprev + 1, 60);
    chk("t6_done_err", last_done_err == 1);
    chk("t6_done_id", last_done_id == 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
